// File: rtl/voice_allocator.sv
// voice_allocator
//   Shares NUM_VOICES tone generators among NUM_KEYS keyboard keys. A scan
//   pointer walks the synchronised key bitmask; a press allocates a voice, a
//   release frees it (or marks it sustained while the pedal is down), a pedal
//   release drops every sustained voice, and panic silences everything.
//
//   Optional feature: define VOICE_STEAL_EN so that a press that finds no free
//   voice takes over the voice with the oldest allocation instead of being
//   dropped.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   key          in   raw key levels, 1 = held (2-flop synchronised)
//   sustain      in   sustain pedal level (2-flop synchronised)
//   panic        in   all-notes-off level (2-flop synchronised)
//   note         out  bitmask of keys currently owning a voice (registered)
//   voice_key    out  key index per voice, voice v at [v*KEY_W +: KEY_W]
//   voice_active out  voice owns a key (held or sustained)
//   voice_trig   out  1-cycle pulse when a voice is (re)assigned
//   overflow     out  1-cycle pulse when a press finds no free voice
module voice_allocator #(
  parameter int NUM_KEYS   = 27,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         key,
  input  logic                        sustain,
  input  logic                        panic,
  output logic [NUM_KEYS-1:0]         note,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES-1:0]       voice_trig,
  output logic                        overflow
);

  localparam int RANK_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [2:0] {SCAN, ALLOC, FREE, SUSREL, PANIC} state_t;

  state_t                              state_q, state_d;
  logic [KEY_W-1:0]                    ptr_q, ptr_d;
  logic [NUM_KEYS-1:0]                 prev_q, prev_d;
  logic [NUM_KEYS-1:0]                 key_s1_q, key_s_q;
  logic                                sus_s1_q, sus_s_q;
  logic                                pan_s1_q, pan_s_q;
  logic                                sus_prev_q, sus_prev_d;
  logic [NUM_VOICES-1:0]               sust_q, sust_d;
  logic [NUM_VOICES-1:0][RANK_W-1:0]   rank_q, rank_d;
  logic [NUM_VOICES-1:0][KEY_W-1:0]    vkey_q, vkey_d;
  logic [NUM_VOICES-1:0]               active_q, active_d;
  logic [NUM_VOICES-1:0]               trig_q, trig_d;
  logic                                ovf_q, ovf_d;
  logic [NUM_KEYS-1:0]                 note_q, note_d;

  logic [KEY_W-1:0]                    ptr_next;
  logic                                own_hit, free_hit;
  logic [RANK_W-1:0]                   own_idx, free_idx, old_idx;
  logic                                alloc_go;
  logic [RANK_W-1:0]                   alloc_idx;

  assign ptr_next = (ptr_q == KEY_W'(NUM_KEYS - 1)) ? '0 : ptr_q + 1'b1;

  // Voice lookups: owner of the key at ptr, lowest free voice, oldest voice.
  always_comb begin
    own_hit  = 1'b0;
    own_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!own_hit && active_q[v] && (vkey_q[v] == ptr_q)) begin
        own_hit = 1'b1;
        own_idx = RANK_W'(v);
      end
      if (!free_hit && !active_q[v]) begin
        free_hit = 1'b1;
        free_idx = RANK_W'(v);
      end
      if (rank_q[v] == RANK_W'(NUM_VOICES - 1)) old_idx = RANK_W'(v);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    prev_d     = prev_q;
    sus_prev_d = sus_prev_q;
    sust_d     = sust_q;
    rank_d     = rank_q;
    vkey_d     = vkey_q;
    active_d   = active_q;
    trig_d     = '0;
    ovf_d      = 1'b0;
    alloc_go   = 1'b0;
    alloc_idx  = '0;

    note_d = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (active_q[v]) note_d[vkey_q[v]] = 1'b1;
    end

    case (state_q)
      SCAN: begin
        // Pedal history only advances here so a pedal release that happens
        // during ALLOC/FREE is still seen on the next SCAN cycle.
        sus_prev_d = sus_s_q;
        if (pan_s_q) begin
          // Silence on entry so voices drop one cycle earlier.
          state_d  = PANIC;
          active_d = '0;
          sust_d   = '0;
          prev_d   = key_s_q;
        end else if (sus_prev_q && !sus_s_q) begin
          state_d = SUSREL;
        end else if (key_s_q[ptr_q] && !prev_q[ptr_q]) begin
          state_d = ALLOC;
        end else if (!key_s_q[ptr_q] && prev_q[ptr_q]) begin
          state_d = FREE;
        end else begin
          ptr_d = ptr_next;
        end
      end

      ALLOC: begin
        prev_d[ptr_q] = 1'b1;
        if (own_hit) begin
          alloc_go       = 1'b1;
          alloc_idx      = own_idx;
          sust_d[own_idx] = 1'b0;
        end else if (free_hit) begin
          alloc_go  = 1'b1;
          alloc_idx = free_idx;
        end else begin
          ovf_d = 1'b1;
`ifdef VOICE_STEAL_EN
          alloc_go        = 1'b1;
          alloc_idx       = old_idx;
          sust_d[old_idx] = 1'b0;
`endif
        end
        if (alloc_go) begin
          vkey_d[alloc_idx]   = ptr_q;
          active_d[alloc_idx] = 1'b1;
          trig_d[alloc_idx]   = 1'b1;
          // Move the assigned voice to the front of the age order.
          for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (rank_q[v] < rank_q[alloc_idx]) rank_d[v] = rank_q[v] + 1'b1;
          end
          rank_d[alloc_idx] = '0;
        end
        state_d = SCAN;
        ptr_d   = ptr_next;
      end

      FREE: begin
        prev_d[ptr_q] = 1'b0;
        if (own_hit) begin
          if (sus_s_q) sust_d[own_idx]   = 1'b1;
          else         active_d[own_idx] = 1'b0;
        end
        state_d = SCAN;
        ptr_d   = ptr_next;
      end

      SUSREL: begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (sust_q[v]) begin
            active_d[v] = 1'b0;
            sust_d[v]   = 1'b0;
          end
        end
        state_d = SCAN;
      end

      PANIC: begin
        active_d = '0;
        sust_d   = '0;
        prev_d   = key_s_q;
        if (!pan_s_q) begin
          state_d = SCAN;
          ptr_d   = '0;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SCAN;
      ptr_q      <= '0;
      prev_q     <= '0;
      key_s1_q   <= '0;
      key_s_q    <= '0;
      sus_s1_q   <= 1'b0;
      sus_s_q    <= 1'b0;
      pan_s1_q   <= 1'b0;
      pan_s_q    <= 1'b0;
      sus_prev_q <= 1'b0;
      sust_q     <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) rank_q[v] <= RANK_W'(v);
      vkey_q     <= '0;
      active_q   <= '0;
      trig_q     <= '0;
      ovf_q      <= 1'b0;
      note_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      prev_q     <= prev_d;
      key_s1_q   <= key;
      key_s_q    <= key_s1_q;
      sus_s1_q   <= sustain;
      sus_s_q    <= sus_s1_q;
      pan_s1_q   <= panic;
      pan_s_q    <= pan_s1_q;
      sus_prev_q <= sus_prev_d;
      sust_q     <= sust_d;
      rank_q     <= rank_d;
      vkey_q     <= vkey_d;
      active_q   <= active_d;
      trig_q     <= trig_d;
      ovf_q      <= ovf_d;
      note_q     <= note_d;
    end
  end

  assign note         = note_q;
  assign voice_key    = vkey_q;
  assign voice_active = active_q;
  assign voice_trig   = trig_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
//   Directed, table-driven bench for voice_allocator: each table row applies
//   key/sustain/panic levels, lets the scan settle and compares note,
//   voice_active, voice_key and the number of trig/overflow pulses seen.
//   Hand-written sequences cover pedal-release timing, press-to-trig latency,
//   reset in the middle of an allocation and a simultaneous two-key press.
module tb_voice_allocator;

  localparam int NK = 27;
  localparam int NV = 4;
  localparam int KW = 5;
  localparam int SETTLE = 45;

  logic              clk = 1'b0;
  logic              reset;
  logic [NK-1:0]     key;
  logic              sustain;
  logic              panic;
  logic [NK-1:0]     note;
  logic [NV*KW-1:0]  voice_key;
  logic [NV-1:0]     voice_active;
  logic [NV-1:0]     voice_trig;
  logic              overflow;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) dut (
    .clk          (clk),
    .reset        (reset),
    .key          (key),
    .sustain      (sustain),
    .panic        (panic),
    .note         (note),
    .voice_key    (voice_key),
    .voice_active (voice_active),
    .voice_trig   (voice_trig),
    .overflow     (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor: counts trig/overflow pulses and any pulse longer than 1 cycle.
  int            trig_cnt [NV] = '{default: 0};
  int            ovf_cnt  = 0;
  int            long_cnt = 0;
  logic [NV-1:0] last_trig = '0;
  logic          last_ovf  = 1'b0;

  always @(negedge clk) begin
    for (int v = 0; v < NV; v++) if (voice_trig[v]) trig_cnt[v]++;
    if (overflow) ovf_cnt++;
    if (((voice_trig & last_trig) != '0) || (overflow && last_ovf)) long_cnt++;
    last_trig = voice_trig;
    last_ovf  = overflow;
  end

  typedef struct {
    logic [NK-1:0]    key;
    logic             sus;
    logic             pan;
    logic [NK-1:0]    note;
    logic [NV-1:0]    act;
    logic [NV*KW-1:0] vk;
    logic             chk_vk;
    logic [NV-1:0]    trig;
    logic             ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [NV*KW-1:0] vk4(input int a3, input int a2, input int a1, input int a0);
    return {KW'(a3), KW'(a2), KW'(a1), KW'(a0)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0 [NV];
    int ov0;
    int lat;
    int n_rel;
    logic [2*NV-1:0] got_t, exp_t;

    // key, sus, pan | note, act, voice_key, chk_vk, trig, ovf
    tbl.push_back('{27'h0000008, 1'b0, 1'b0, 27'h0000008, 4'b0001, vk4(0,0,0,3), 1'b1, 4'b0001, 1'b0});
    tbl.push_back('{27'h0000000, 1'b0, 1'b0, 27'h0000000, 4'b0000, vk4(0,0,0,3), 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{27'h0000001, 1'b0, 1'b0, 27'h0000001, 4'b0001, vk4(0,0,0,0), 1'b1, 4'b0001, 1'b0});
    tbl.push_back('{27'h0000003, 1'b0, 1'b0, 27'h0000003, 4'b0011, vk4(0,0,1,0), 1'b1, 4'b0010, 1'b0});
    tbl.push_back('{27'h0000007, 1'b0, 1'b0, 27'h0000007, 4'b0111, vk4(0,2,1,0), 1'b1, 4'b0100, 1'b0});
    tbl.push_back('{27'h000000F, 1'b0, 1'b0, 27'h000000F, 4'b1111, vk4(3,2,1,0), 1'b1, 4'b1000, 1'b0});
`ifdef VOICE_STEAL_EN
    tbl.push_back('{27'h000001F, 1'b0, 1'b0, 27'h000001E, 4'b1111, vk4(3,2,1,4), 1'b1, 4'b0001, 1'b1});
    tbl.push_back('{27'h0000000, 1'b0, 1'b0, 27'h0000000, 4'b0000, vk4(3,2,1,4), 1'b1, 4'b0000, 1'b0});
`else
    tbl.push_back('{27'h000001F, 1'b0, 1'b0, 27'h000000F, 4'b1111, vk4(3,2,1,0), 1'b1, 4'b0000, 1'b1});
    tbl.push_back('{27'h0000000, 1'b0, 1'b0, 27'h0000000, 4'b0000, vk4(3,2,1,0), 1'b1, 4'b0000, 1'b0});
`endif
    tbl.push_back('{27'h0000008, 1'b0, 1'b0, 27'h0000008, 4'b0001, vk4(3,2,1,3), 1'b1, 4'b0001, 1'b0});
    tbl.push_back('{27'h0000008, 1'b1, 1'b0, 27'h0000008, 4'b0001, vk4(3,2,1,3), 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{27'h0000000, 1'b1, 1'b0, 27'h0000008, 4'b0001, vk4(3,2,1,3), 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{27'h0000008, 1'b1, 1'b0, 27'h0000008, 4'b0001, vk4(3,2,1,3), 1'b1, 4'b0001, 1'b0});
    tbl.push_back('{27'h0000020, 1'b1, 1'b0, 27'h0000028, 4'b0011, vk4(3,2,5,3), 1'b1, 4'b0010, 1'b0});
    tbl.push_back('{27'h0000020, 1'b0, 1'b0, 27'h0000020, 4'b0010, vk4(3,2,5,3), 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{27'h0000000, 1'b0, 1'b0, 27'h0000000, 4'b0000, vk4(3,2,5,3), 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{27'h0000001, 1'b0, 1'b0, 27'h0000001, 4'b0001, vk4(3,2,5,0), 1'b1, 4'b0001, 1'b0});
    tbl.push_back('{27'h0000003, 1'b0, 1'b0, 27'h0000003, 4'b0011, vk4(3,2,1,0), 1'b1, 4'b0010, 1'b0});
    tbl.push_back('{27'h0000007, 1'b0, 1'b0, 27'h0000007, 4'b0111, vk4(3,2,1,0), 1'b1, 4'b0100, 1'b0});
    tbl.push_back('{27'h0000007, 1'b0, 1'b1, 27'h0000000, 4'b0000, vk4(3,2,1,0), 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{27'h0000007, 1'b0, 1'b0, 27'h0000000, 4'b0000, vk4(3,2,1,0), 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{27'h0000006, 1'b0, 1'b0, 27'h0000000, 4'b0000, vk4(3,2,1,0), 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{27'h0000007, 1'b0, 1'b0, 27'h0000001, 4'b0001, vk4(3,2,1,0), 1'b1, 4'b0001, 1'b0});
    tbl.push_back('{27'h0000000, 1'b0, 1'b0, 27'h0000000, 4'b0000, vk4(3,2,1,0), 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{27'h4000001, 1'b0, 1'b0, 27'h4000001, 4'b0011, vk4(0,0,0,0), 1'b0, 4'b0011, 1'b0});
    tbl.push_back('{27'h0000000, 1'b0, 1'b0, 27'h0000000, 4'b0000, vk4(0,0,0,0), 1'b0, 4'b0000, 1'b0});

    // Reset state
    reset = 1'b0; key = '0; sustain = 1'b0; panic = 1'b0;
    ticks(3);
    check("rst_note",   64'(note),         64'h0);
    check("rst_vkey",   64'(voice_key),    64'h0);
    check("rst_active", 64'(voice_active), 64'h0);
    check("rst_trig",   64'(voice_trig),   64'h0);
    check("rst_ovf",    64'(overflow),     64'h0);
    reset = 1'b1;
    tick();

    // Table-driven settled-state vectors
    for (int i = 0; i < tbl.size(); i++) begin
      for (int v = 0; v < NV; v++) t0[v] = trig_cnt[v];
      ov0 = ovf_cnt;
      key = tbl[i].key; sustain = tbl[i].sus; panic = tbl[i].pan;
      ticks(SETTLE);
      check($sformatf("row%0d_note", i),   64'(note),         64'(tbl[i].note));
      check($sformatf("row%0d_active", i), 64'(voice_active), 64'(tbl[i].act));
      if (tbl[i].chk_vk)
        check($sformatf("row%0d_vkey", i), 64'(voice_key), 64'(tbl[i].vk));
      for (int v = 0; v < NV; v++) begin
        got_t[2*v +: 2] = 2'(trig_cnt[v] - t0[v]);
        exp_t[2*v +: 2] = {1'b0, tbl[i].trig[v]};
      end
      check($sformatf("row%0d_trig_pulses", i), 64'(got_t), 64'(exp_t));
      check($sformatf("row%0d_ovf_pulses", i),  64'(ovf_cnt - ov0), 64'(tbl[i].ovf));
    end

    // Pedal release: sustained voice drops within 4 cycles of sustain falling
    key = 27'h8; ticks(SETTLE);
    sustain = 1'b1; ticks(5);
    key = '0; ticks(SETTLE);
    check("sus_hold_active", 64'(voice_active), 64'b0001);
    check("sus_hold_note",   64'(note),         64'h8);
    sustain = 1'b0;
    n_rel = 0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (voice_active == '0) begin
        n_rel = n;
        break;
      end
    end
    check("susrel_within_4", 64'((n_rel >= 1) && (n_rel <= 4)), 64'h1);
    tick();
    check("susrel_note", 64'(note), 64'h0);

    // Press-to-trig latency with voice 0 already busy on key 5
    key = '0;
    do_reset();
    ticks(3);
    key = 27'h20; ticks(SETTLE);
    key = 27'h28;
    lat = 0;
    for (int n = 1; n <= 31; n++) begin
      tick();
      if (voice_trig != '0) begin
        lat = n;
        break;
      end
    end
    check("lat_within_31", 64'(lat > 0), 64'h1);
    if (lat == 0) lat = 31;
    check("lat_trig",     64'(voice_trig),        64'b0010);
    check("lat_vkey1",    64'(voice_key[9:5]),    64'd3);
    tick();
    check("lat_trig_off", 64'(voice_trig),        64'h0);
    check("lat_note",     64'(note),              64'h28);

    // Same sequence again, reset asserted while the key-3 allocation is in flight
    key = '0;
    do_reset();
    ticks(3);
    key = 27'h20; ticks(SETTLE);
    key = 27'h28;
    ticks(lat - 1);
    check("pre_rst_active", 64'(voice_active), 64'b0001);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_outputs", {note, voice_key, voice_active, voice_trig, overflow}, 64'h0);
    tick();
    check("midrst_held", {note, voice_key, voice_active, voice_trig, overflow}, 64'h0);
    key = '0;
    tick();
    reset = 1'b1;
    tick();

    // Keys 0 and 26 together after reset
    for (int v = 0; v < NV; v++) t0[v] = trig_cnt[v];
    ov0 = ovf_cnt;
    key = 27'h4000001; ticks(SETTLE);
    check("pair_active", 64'(voice_active), 64'b0011);
    check("pair_note",   64'(note),         64'h4000001);
    check("pair_ovf",    64'(ovf_cnt - ov0), 64'h0);
    check("pair_trig",   64'((trig_cnt[0] - t0[0]) + (trig_cnt[1] - t0[1])), 64'd2);

    check("pulse_width_1cycle", 64'(long_cnt), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
